// File: rtl/exit_park.sv
// Exit-side occupancy keeper: validates exit requests against the 8-space occupancy
// register, clears the space on a valid exit and holds the exit gate open for GATE_CYCLES.
module exit_park #(
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_commit,
    input  logic [2:0] entry_space,
    input  logic       exit_req,
    input  logic [2:0] exit_space,
    output logic       exit_ack,
    output logic       exit_err,
    output logic       gate_open,
    output logic       busy,
    output logic [7:0] parking_capacity,
    output logic [3:0] free_count
);

    typedef enum logic [1:0] {StIdle, StCheck, StOpen} state_e;

    localparam logic [7:0] TimerLoad = 8'(GATE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] req_space_q, req_space_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] cap_q, cap_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       gate_q, gate_d;
    logic       busy_q, busy_d;

    logic       hit;
    logic [7:0] set_mask;
    logic [7:0] clr_mask;

    assign hit = cap_q[req_space_q];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            req_space_q <= 3'd0;
            timer_q     <= 8'd0;
            cap_q       <= 8'd0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            gate_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_space_q <= req_space_d;
            timer_q     <= timer_d;
            cap_q       <= cap_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            gate_q      <= gate_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        req_space_d = req_space_q;
        timer_d     = timer_q;
        set_mask    = 8'd0;
        clr_mask    = 8'd0;

        unique case (state_q)
            StIdle: begin
                if (exit_req) begin
                    req_space_d = exit_space;
                    state_d     = StCheck;
                end
            end
            StCheck: begin
                if (hit) begin
                    clr_mask[req_space_q] = 1'b1;
                    timer_d               = TimerLoad;
                    state_d               = StOpen;
                end else begin
                    state_d = StIdle;
                end
            end
            StOpen: begin
                if (timer_q == 8'd0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (entry_commit) begin
            set_mask[entry_space] = 1'b1;
        end
        // Set is applied after clear so a re-taken space stays occupied
        cap_d = (cap_q & ~clr_mask) | set_mask;
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        ack_d  = (state_q == StCheck) && hit;
        err_d  = (state_q == StCheck) && !hit;
        gate_d = (state_d == StOpen);
        busy_d = (state_d != StIdle);
    end

    always_comb begin
        logic [3:0] ones;
        ones = 4'd0;
        for (int i = 0; i < 8; i++) begin
            ones = ones + 4'(cap_q[i]);
        end
        free_count = 4'd8 - ones;
    end

    assign exit_ack         = ack_q;
    assign exit_err         = err_q;
    assign gate_open        = gate_q;
    assign busy             = busy_q;
    assign parking_capacity = cap_q;

endmodule

// File: tb/tb_exit_park.sv
// Directed self-checking bench for exit_park with GATE_CYCLES = 4.
module tb_exit_park;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_commit = 1'b0;
    logic [2:0] entry_space = 3'd0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_space = 3'd0;
    logic       exit_ack;
    logic       exit_err;
    logic       gate_open;
    logic       busy;
    logic [7:0] parking_capacity;
    logic [3:0] free_count;

    int n_checks = 0;
    int n_fail   = 0;

    exit_park #(.GATE_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .entry_commit     (entry_commit),
        .entry_space      (entry_space),
        .exit_req         (exit_req),
        .exit_space       (exit_space),
        .exit_ack         (exit_ack),
        .exit_err         (exit_err),
        .gate_open        (gate_open),
        .busy             (busy),
        .parking_capacity (parking_capacity),
        .free_count       (free_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ack, input logic err,
                           input logic gate, input logic bsy);
        chk({tag, ".ack"},  8'(exit_ack),  8'(ack));
        chk({tag, ".err"},  8'(exit_err),  8'(err));
        chk({tag, ".gate"}, 8'(gate_open), 8'(gate));
        chk({tag, ".busy"}, 8'(busy),      8'(bsy));
    endtask

    initial begin
        // 1. reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst.cap", parking_capacity, 8'h00);
        chk("rst.free", 8'(free_count), 8'd8);
        chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // 2. entries 0, 3, 7
        entry_commit = 1'b1;
        entry_space = 3'd0; step();
        entry_space = 3'd3; step();
        entry_space = 3'd7; step();
        entry_commit = 1'b0;
        chk("ent.cap", parking_capacity, 8'h89);
        chk("ent.free", 8'(free_count), 8'd5);

        // 3. valid exit of space 3
        exit_req = 1'b1; exit_space = 3'd3;
        step();
        exit_req = 1'b0;
        chk_out("ex3.chk", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ex3.chk.cap", parking_capacity, 8'h89);
        step();
        chk_out("ex3.o1", 1'b1, 1'b0, 1'b1, 1'b1);
        chk("ex3.cap", parking_capacity, 8'h81);
        chk("ex3.free", 8'(free_count), 8'd6);
        step(); chk_out("ex3.o2", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); chk_out("ex3.o3", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); chk_out("ex3.o4", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); chk_out("ex3.done", 1'b0, 1'b0, 1'b0, 1'b0);

        // 4. exit of an empty space
        exit_req = 1'b1; exit_space = 3'd2;
        step();
        exit_req = 1'b0;
        chk_out("ex2.chk", 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk_out("ex2.err", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ex2.cap", parking_capacity, 8'h81);
        step();
        chk_out("ex2.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // 5a. exit_req during OPEN is dropped
        exit_req = 1'b1; exit_space = 3'd7;
        step();
        exit_req = 1'b0;
        step();
        chk_out("ex7.o1", 1'b1, 1'b0, 1'b1, 1'b1);
        chk("ex7.cap", parking_capacity, 8'h01);
        exit_req = 1'b1; exit_space = 3'd0;
        step();
        exit_req = 1'b0;
        chk_out("drop.o2", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); chk_out("drop.o3", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); chk_out("drop.o4", 1'b0, 1'b0, 1'b1, 1'b1);
        step(); chk_out("drop.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop.cap", parking_capacity, 8'h01);
        step(); chk_out("drop.still", 1'b0, 1'b0, 1'b0, 1'b0);

        // 5b. same-bit set and clear in CHECK: set wins, exit still accepted
        exit_req = 1'b1; exit_space = 3'd0;
        step();
        exit_req = 1'b0;
        entry_commit = 1'b1; entry_space = 3'd0;
        step();
        entry_commit = 1'b0;
        chk_out("same.o1", 1'b1, 1'b0, 1'b1, 1'b1);
        chk("same.cap", parking_capacity, 8'h01);
        step(); step(); step(); step();
        chk_out("same.done", 1'b0, 1'b0, 1'b0, 1'b0);

        // 6. reset in the second OPEN cycle
        entry_commit = 1'b1; entry_space = 3'd5;
        step();
        entry_commit = 1'b0;
        chk("r6.cap", parking_capacity, 8'h21);
        exit_req = 1'b1; exit_space = 3'd5;
        step();
        exit_req = 1'b0;
        step();
        chk_out("r6.o1", 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        chk_out("r6.o2", 1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_out("r6.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("r6.cap0", parking_capacity, 8'h00);
        chk("r6.free", 8'(free_count), 8'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
